// File: rtl/sd_multi_block_reader.sv
// Reads a run of 512-byte SD blocks through a byte-wide controller and
// packs the bytes into little-endian words for a word-addressed sink.
module sd_multi_block_reader #(
    parameter int MAX_BLOCKS     = 4,
    parameter int WORD_BYTES     = 4,
    parameter int TIMEOUT_CYCLES = 1000000,
    localparam int AW            = $clog2(MAX_BLOCKS * 512 / WORD_BYTES)
) (
    input  logic                    clk_spi,
    input  logic                    reset,
    input  logic                    start,
    input  logic [31:0]             base_block,
    input  logic [6:0]              block_count,
    input  logic                    ctrl_ready,
    output logic                    ctrl_rd,
    output logic [31:0]             ctrl_address,
    input  logic                    ctrl_byte_available,
    input  logic [7:0]              ctrl_dout,
    output logic                    wr_en,
    output logic [AW-1:0]           wr_addr,
    output logic [8*WORD_BYTES-1:0] wr_data,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [6:0]              blocks_done
);

    localparam int LW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, WAIT_READY, READ, NEXT, FINISH} state_t;

    state_t                  state_reg, state_next;
    logic [31:0]             base_reg;
    logic [6:0]              count_reg;
    logic [8:0]              byte_cnt_reg;
    logic [LW-1:0]           lane_reg;
    logic [AW-1:0]           word_cnt_reg;
    logic [TW-1:0]           tmo_cnt_reg;
    logic                    avail_reg, avail_prev_reg;
    logic [7:0]              dout_reg;
    logic [8*WORD_BYTES-1:0] word_next;

    logic start_accept, start_reject, timeout, issue_rd;
    logic byte_event, lane_last, tmo_hit;

    // Byte data is registered alongside the strobe so the captured byte lines
    // up with the detected rising edge.
    assign byte_event = (state_reg == READ) && avail_reg && !avail_prev_reg;
    assign lane_last  = (lane_reg == LW'(WORD_BYTES - 1));
    assign tmo_hit    = (tmo_cnt_reg == TW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk_spi or posedge reset) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next   = state_reg;
        start_accept = 1'b0;
        start_reject = 1'b0;
        timeout      = 1'b0;
        issue_rd     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (block_count != 7'd0 && block_count <= 7'(MAX_BLOCKS)) begin
                        start_accept = 1'b1;
                        state_next   = WAIT_READY;
                    end else begin
                        start_reject = 1'b1;
                    end
                end
            end
            WAIT_READY: begin
                busy = 1'b1;
                if (tmo_hit) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end else if (ctrl_ready) begin
                    issue_rd   = 1'b1;
                    state_next = READ;
                end
            end
            READ: begin
                busy = 1'b1;
                if (byte_event) begin
                    if (byte_cnt_reg == 9'd511) state_next = NEXT;
                end else if (tmo_hit) begin
                    timeout    = 1'b1;
                    state_next = IDLE;
                end
            end
            NEXT: begin
                busy       = 1'b1;
                state_next = (blocks_done + 7'd1 == count_reg) ? FINISH : WAIT_READY;
            end
            FINISH: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // One holding register per byte lane; the completed word merges the
    // incoming byte into its lane so it can be written the following cycle.
    for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
        logic [7:0] data_reg;
        always_ff @(posedge clk_spi or posedge reset) begin
            if (reset)                                    data_reg <= 8'd0;
            else if (byte_event && lane_reg == LW'(gi))   data_reg <= dout_reg;
        end
        assign word_next[gi*8 +: 8] = (lane_reg == LW'(gi)) ? dout_reg : data_reg;
    end

    always_ff @(posedge clk_spi or posedge reset) begin
        if (reset) begin
            avail_reg      <= 1'b0;
            avail_prev_reg <= 1'b0;
            dout_reg       <= 8'd0;
            base_reg       <= 32'd0;
            count_reg      <= 7'd0;
            byte_cnt_reg   <= 9'd0;
            lane_reg       <= '0;
            word_cnt_reg   <= '0;
            tmo_cnt_reg    <= '0;
            ctrl_rd        <= 1'b0;
            ctrl_address   <= 32'd0;
            wr_en          <= 1'b0;
            wr_addr        <= '0;
            wr_data        <= '0;
            error          <= 1'b0;
            blocks_done    <= 7'd0;
        end else begin
            avail_reg      <= ctrl_byte_available;
            avail_prev_reg <= avail_reg;
            dout_reg       <= ctrl_dout;
            ctrl_rd        <= issue_rd;
            error          <= start_reject || timeout;
            wr_en          <= byte_event && lane_last;

            if (issue_rd) ctrl_address <= base_reg + {25'd0, blocks_done};

            if (byte_event) begin
                byte_cnt_reg <= byte_cnt_reg + 9'd1;
                lane_reg     <= lane_last ? '0 : lane_reg + 1'b1;
                if (lane_last) begin
                    wr_data      <= word_next;
                    wr_addr      <= word_cnt_reg;
                    word_cnt_reg <= word_cnt_reg + 1'b1;
                end
            end

            if (state_reg == NEXT) blocks_done <= blocks_done + 7'd1;

            if (start_accept) begin
                base_reg     <= base_block;
                count_reg    <= block_count;
                blocks_done  <= 7'd0;
                byte_cnt_reg <= 9'd0;
                lane_reg     <= '0;
                word_cnt_reg <= '0;
            end

            if (state_next != state_reg || byte_event)
                tmo_cnt_reg <= '0;
            else if (state_reg == WAIT_READY || state_reg == READ)
                tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
        end
    end

endmodule

// File: tb/tb_sd_multi_block_reader.sv
// Directed bench for sd_multi_block_reader: a byte-source model feeds blocks,
// a scoreboard queue holds expected words and read addresses.
module tb_sd_multi_block_reader;

    localparam int MB = 4;
    localparam int WB = 4;
    localparam int TO = 16;
    localparam int AW = $clog2(MB * 512 / WB);

    logic          clk_spi = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [31:0]   base_block = 32'd0;
    logic [6:0]    block_count = 7'd0;
    logic          ctrl_ready = 1'b1;
    logic          ctrl_rd;
    logic [31:0]   ctrl_address;
    logic          ctrl_byte_available = 1'b0;
    logic [7:0]    ctrl_dout = 8'd0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          busy, done, error;
    logic [6:0]    blocks_done;

    sd_multi_block_reader #(
        .MAX_BLOCKS(MB), .WORD_BYTES(WB), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_spi(clk_spi), .reset(reset), .start(start),
        .base_block(base_block), .block_count(block_count),
        .ctrl_ready(ctrl_ready), .ctrl_rd(ctrl_rd), .ctrl_address(ctrl_address),
        .ctrl_byte_available(ctrl_byte_available), .ctrl_dout(ctrl_dout),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .error(error), .blocks_done(blocks_done)
    );

    always #5 clk_spi = ~clk_spi;

    int total = 0;
    int bad = 0;
    logic [31:0] exp_word_q[$];
    int          exp_addr_q[$];
    logic [31:0] exp_rd_q[$];
    int rd_cnt = 0, wr_cnt = 0, done_cnt = 0, err_cnt = 0;
    int byte_idx = 0, word_idx = 0;
    logic [31:0] acc = 32'd0;
    int r0, w0, d0, e0, c;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Output-side scoreboard: every write strobe and read command is popped here.
    always @(negedge clk_spi) begin
        if (wr_en) begin
            wr_cnt++;
            check("wr_expected", 64'(exp_word_q.size() > 0), 64'd1);
            if (exp_word_q.size() > 0) begin
                check("wr_data", 64'(wr_data), 64'(exp_word_q.pop_front()));
                check("wr_addr", 64'(wr_addr), 64'(exp_addr_q.pop_front()));
            end
        end
        if (ctrl_rd) begin
            rd_cnt++;
            check("rd_expected", 64'(exp_rd_q.size() > 0), 64'd1);
            if (exp_rd_q.size() > 0)
                check("ctrl_address", 64'(ctrl_address), 64'(exp_rd_q.pop_front()));
        end
        if (done)  done_cnt++;
        if (error) err_cnt++;
    end

    function automatic logic [7:0] pattern(input int mode, input int i);
        int v;
        v = (mode == 0) ? i : (i * 7 + 3);
        return v[7:0];
    endfunction

    task automatic new_transfer();
        byte_idx = 0;
        word_idx = 0;
        acc      = 32'd0;
    endtask

    // Model update happens before driving so the expected word is queued
    // ahead of the DUT's write strobe.
    task automatic drive_byte(input logic [7:0] v, input int hold);
        acc[(byte_idx % 4) * 8 +: 8] = v;
        byte_idx++;
        if (byte_idx % 4 == 0) begin
            exp_word_q.push_back(acc);
            exp_addr_q.push_back(word_idx);
            word_idx++;
        end
        ctrl_dout = v;
        ctrl_byte_available = 1'b1;
        repeat (hold) @(negedge clk_spi);
        ctrl_byte_available = 1'b0;
        @(negedge clk_spi);
    endtask

    task automatic send_bytes(input int n, input int hold, input int mode);
        for (int i = 0; i < n; i++) drive_byte(pattern(mode, byte_idx), hold);
    endtask

    task automatic wait_rd(input int target, input string tag);
        int k;
        for (k = 0; k < 300; k++) begin
            if (rd_cnt >= target) break;
            @(negedge clk_spi);
        end
        check(tag, 64'(k < 300), 64'd1);
    endtask

    task automatic wait_done(input int target, input string tag);
        int k;
        for (k = 0; k < 300; k++) begin
            if (done_cnt >= target) break;
            @(negedge clk_spi);
        end
        check(tag, 64'(k < 300), 64'd1);
    endtask

    task automatic do_start(input logic [31:0] base, input logic [6:0] cnt);
        base_block  = base;
        block_count = cnt;
        start       = 1'b1;
        @(negedge clk_spi);
        start       = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk_spi);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_ctrl_rd", 64'(ctrl_rd), 64'd0);
        check("rst_blocks_done", 64'(blocks_done), 64'd0);
        reset = 1'b0;
        @(negedge clk_spi);

        // single block
        new_transfer();
        exp_rd_q.push_back(32'h10);
        r0 = rd_cnt; w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
        do_start(32'h10, 7'd1);
        check("t1_busy_after_start", 64'(busy), 64'd1);
        wait_rd(r0 + 1, "t1_rd_seen");
        send_bytes(512, 1, 0);
        wait_done(d0 + 1, "t1_done_seen");
        repeat (4) @(negedge clk_spi);
        check("t1_words", 64'(wr_cnt - w0), 64'd128);
        check("t1_reads", 64'(rd_cnt - r0), 64'd1);
        check("t1_done_pulses", 64'(done_cnt - d0), 64'd1);
        check("t1_errors", 64'(err_cnt - e0), 64'd0);
        check("t1_busy_end", 64'(busy), 64'd0);
        check("t1_blocks_done", 64'(blocks_done), 64'd1);
        check("t1_last_addr", 64'(wr_addr), 64'd127);
        $display("transfer single: base=0x10 words=%0d", wr_cnt - w0);

        // three blocks with address wrap
        new_transfer();
        exp_rd_q.push_back(32'hFFFF_FFFF);
        exp_rd_q.push_back(32'h0);
        exp_rd_q.push_back(32'h1);
        r0 = rd_cnt; w0 = wr_cnt; d0 = done_cnt;
        do_start(32'hFFFF_FFFF, 7'd3);
        for (int b = 0; b < 3; b++) begin
            wait_rd(r0 + b + 1, "t2_rd_seen");
            send_bytes(512, 1, 0);
        end
        wait_done(d0 + 1, "t2_done_seen");
        repeat (4) @(negedge clk_spi);
        check("t2_words", 64'(wr_cnt - w0), 64'd384);
        check("t2_reads", 64'(rd_cnt - r0), 64'd3);
        check("t2_last_addr", 64'(wr_addr), 64'd383);
        check("t2_blocks_done", 64'(blocks_done), 64'd3);
        check("t2_done_pulses", 64'(done_cnt - d0), 64'd1);
        $display("transfer multi: base=0xffffffff words=%0d", wr_cnt - w0);

        // rejected starts
        r0 = rd_cnt; e0 = err_cnt;
        do_start(32'h55, 7'd0);
        check("t3_err_count0", 64'(error), 64'd1);
        check("t3_busy_count0", 64'(busy), 64'd0);
        @(negedge clk_spi);
        do_start(32'h55, 7'(MB + 1));
        check("t3_err_countmax", 64'(error), 64'd1);
        check("t3_busy_countmax", 64'(busy), 64'd0);
        repeat (6) @(negedge clk_spi);
        check("t3_err_pulses", 64'(err_cnt - e0), 64'd2);
        check("t3_reads", 64'(rd_cnt - r0), 64'd0);
        check("t3_busy_end", 64'(busy), 64'd0);
        $display("transfer bad start: errors=%0d", err_cnt - e0);

        // timeout after 100 bytes
        new_transfer();
        exp_rd_q.push_back(32'h100);
        r0 = rd_cnt; w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
        do_start(32'h100, 7'd2);
        wait_rd(r0 + 1, "t4_rd_seen");
        send_bytes(100, 1, 0);
        for (c = 0; c < 100; c++) begin
            if (err_cnt > e0) break;
            @(negedge clk_spi);
        end
        check("t4_timeout_window", 64'(c >= 14 && c <= 21), 64'd1);
        repeat (10) @(negedge clk_spi);
        check("t4_words", 64'(wr_cnt - w0), 64'd25);
        check("t4_err_pulses", 64'(err_cnt - e0), 64'd1);
        check("t4_no_done", 64'(done_cnt - d0), 64'd0);
        check("t4_busy", 64'(busy), 64'd0);
        check("t4_blocks_done", 64'(blocks_done), 64'd0);
        $display("transfer timeout: words=%0d idle_cycles=%0d", wr_cnt - w0, c);

        // held strobe, start while busy
        new_transfer();
        exp_rd_q.push_back(32'h20);
        exp_rd_q.push_back(32'h21);
        r0 = rd_cnt; w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
        do_start(32'h20, 7'd2);
        wait_rd(r0 + 1, "t5_rd0_seen");
        send_bytes(50, 3, 1);
        do_start(32'h999, 7'd1);
        send_bytes(462, 3, 1);
        wait_rd(r0 + 2, "t5_rd1_seen");
        send_bytes(512, 3, 1);
        wait_done(d0 + 1, "t5_done_seen");
        repeat (4) @(negedge clk_spi);
        check("t5_words", 64'(wr_cnt - w0), 64'd256);
        check("t5_reads", 64'(rd_cnt - r0), 64'd2);
        check("t5_errors", 64'(err_cnt - e0), 64'd0);
        check("t5_blocks_done", 64'(blocks_done), 64'd2);
        $display("transfer held: base=0x20 words=%0d", wr_cnt - w0);

        // reset at byte 300 of the second block
        new_transfer();
        exp_rd_q.push_back(32'h40);
        exp_rd_q.push_back(32'h41);
        r0 = rd_cnt; w0 = wr_cnt;
        do_start(32'h40, 7'd2);
        wait_rd(r0 + 1, "t6_rd0_seen");
        send_bytes(512, 1, 0);
        wait_rd(r0 + 2, "t6_rd1_seen");
        send_bytes(300, 1, 0);
        repeat (3) @(negedge clk_spi);
        check("t6_words_before_reset", 64'(wr_cnt - w0), 64'd203);
        reset = 1'b1;
        #1;
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_ctrl_address", 64'(ctrl_address), 64'd0);
        check("t6_rst_wr_addr", 64'(wr_addr), 64'd0);
        check("t6_rst_wr_data", 64'(wr_data), 64'd0);
        check("t6_rst_blocks_done", 64'(blocks_done), 64'd0);
        check("t6_rst_wr_en", 64'(wr_en), 64'd0);
        check("t6_rst_ctrl_rd", 64'(ctrl_rd), 64'd0);
        @(negedge clk_spi);
        reset = 1'b0;
        d0 = done_cnt; e0 = err_cnt;
        repeat (20) @(negedge clk_spi);
        check("t6_no_done", 64'(done_cnt - d0), 64'd0);
        check("t6_no_error", 64'(err_cnt - e0), 64'd0);
        check("t6_idle_busy", 64'(busy), 64'd0);
        new_transfer();
        exp_rd_q.push_back(32'h7);
        r0 = rd_cnt; w0 = wr_cnt;
        do_start(32'h7, 7'd1);
        wait_rd(r0 + 1, "t6_fresh_rd_seen");
        send_bytes(512, 1, 0);
        wait_done(d0 + 1, "t6_fresh_done_seen");
        repeat (4) @(negedge clk_spi);
        check("t6_fresh_words", 64'(wr_cnt - w0), 64'd128);
        check("t6_fresh_blocks_done", 64'(blocks_done), 64'd1);
        $display("transfer after reset: base=0x7 words=%0d", wr_cnt - w0);

        check("final_word_queue_empty", 64'(exp_word_q.size()), 64'd0);
        check("final_rd_queue_empty", 64'(exp_rd_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
